// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending controller.
// All money values are in 5-cent units.
// Optional stock tracking is enabled with the VEND_STOCK_EN macro (see vend_ctrl_multi).
package vend_pkg;

    // Coin codes shared by the acceptor input and the change dispenser output.
    typedef enum logic [1:0] {
        COIN_5   = 2'd0,
        COIN_10  = 2'd1,
        COIN_25  = 2'd2,
        COIN_INV = 2'd3
    } coin_code_t;

    localparam logic [2:0] COIN_VALUE_5  = 3'd1;
    localparam logic [2:0] COIN_VALUE_10 = 3'd2;
    localparam logic [2:0] COIN_VALUE_25 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_t;

    // The price table covers the largest supported product count; a build
    // with fewer items simply never addresses the upper entries.
    localparam int MAX_ITEMS = 16;
    localparam logic [7:0] ITEM_PRICE [MAX_ITEMS] = '{
        8'd5,  8'd7,  8'd10, 8'd15, 8'd20, 8'd25, 8'd30, 8'd35,
        8'd40, 8'd45, 8'd50, 8'd55, 8'd60, 8'd65, 8'd70, 8'd75
    };

    // Unit value of a coin code; the invalid code is worth nothing.
    function automatic logic [2:0] coin_value(input coin_code_t c);
        case (c)
            COIN_5:  return COIN_VALUE_5;
            COIN_10: return COIN_VALUE_10;
            COIN_25: return COIN_VALUE_25;
            default: return 3'd0;
        endcase
    endfunction

    // Price lookup with a full-width index so callers of any select width
    // can zero-extend into it.
    function automatic logic [7:0] item_price(input logic [3:0] idx);
        return ITEM_PRICE[idx];
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change-coin picker: largest coin not exceeding the remaining amount.
// Purely combinational; the caller registers the result.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] amount,
    output logic [1:0]          coin
);

    // Pick 25c, then 10c, else 5c; meaningless (but harmless) when amount is 0.
    always_comb begin
        coin = COIN_5;
        if (amount >= CREDIT_W'(COIN_VALUE_25)) begin
            coin = COIN_25;
        end else if (amount >= CREDIT_W'(COIN_VALUE_10)) begin
            coin = COIN_10;
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit accumulation, item selection,
// greedy change return. Define VEND_STOCK_EN to add per-item stock counters
// (extra ports stock_load/stock_item/stock_val); without it stock is unlimited.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_sel,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
    input  logic                         cancel,
    input  logic                         chg_ready,
    output logic                         coin_reject,
    output logic                         vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
    output logic                         sel_deny,
    output logic                         chg_valid,
    output logic [1:0]                   chg_coin,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy
`ifdef VEND_STOCK_EN
    ,
    input  logic                         stock_load,
    input  logic [$clog2(NUM_ITEMS)-1:0] stock_item,
    input  logic [7:0]                   stock_val
`endif
);

    localparam int SEL_W = $clog2(NUM_ITEMS);

    vend_state_t         state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [SEL_W-1:0]    vend_item_reg, vend_item_next;
    logic                coin_reject_reg, coin_reject_next;
    logic                sel_deny_reg, sel_deny_next;
    logic                vend_valid_reg;
    logic                chg_valid_reg;
    logic [1:0]          chg_coin_reg;
    logic                busy_reg;

    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] chg_value;
    logic                sel_in_range;
    logic                sel_in_stock;
    logic                sel_ok;
    logic [1:0]          greedy_coin;

    // Coin acceptance: valid code and the sum stays within the credit ceiling.
    assign coin_val   = CREDIT_W'(coin_value(coin_code_t'(coin_sel)));
    assign credit_sum = {1'b0, credit_reg} + {1'b0, coin_val};
    assign coin_ok    = (coin_sel != COIN_INV) &&
                        (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    // Selection checks: index exists, enough credit, and item available.
    assign sel_in_range = 32'(sel_item) < 32'(NUM_ITEMS);
    assign sel_price    = CREDIT_W'(item_price(4'(sel_item)));
    assign vend_price   = CREDIT_W'(item_price(4'(vend_item_reg)));
    assign sel_ok       = sel_in_range && (credit_reg >= sel_price) && sel_in_stock;

    // Value of the coin currently offered to the dispenser.
    assign chg_value = CREDIT_W'(coin_value(coin_code_t'(chg_coin_reg)));

`ifdef VEND_STOCK_EN
    logic [NUM_ITEMS-1:0][7:0] stock_level;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
            logic [7:0] cnt_reg;

            // Per-item counter: a load overrides the decrement of a vend in the same cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= 8'd0;
                end else if (stock_load && (stock_item == SEL_W'(gi))) begin
                    cnt_reg <= stock_val;
                end else if (vend_valid_reg && (vend_item_reg == SEL_W'(gi)) &&
                             (cnt_reg != 8'd0)) begin
                    cnt_reg <= cnt_reg - 8'd1;
                end
            end

            assign stock_level[gi] = cnt_reg;
        end
    endgenerate

    assign sel_in_stock = sel_in_range && (stock_level[sel_item] != 8'd0);
`else
    assign sel_in_stock = 1'b1;
`endif

    // Greedy coin for the credit that will remain after this edge.
    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .amount (credit_next),
        .coin   (greedy_coin)
    );

    // Next-state, credit and pulse decisions; cancel beats selection beats coin.
    always_comb begin
        state_next       = state_reg;
        credit_next      = credit_reg;
        vend_item_next   = vend_item_reg;
        coin_reject_next = 1'b0;
        sel_deny_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                sel_deny_next = sel_valid;
                if (coin_valid) begin
                    if (coin_ok) begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                        state_next  = ST_CREDIT;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    state_next       = ST_CHANGE;
                    coin_reject_next = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_next = coin_valid;
                    if (sel_ok) begin
                        state_next     = ST_VEND;
                        vend_item_next = sel_item;
                    end else begin
                        sel_deny_next = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_next = coin_valid;
                credit_next      = credit_reg - vend_price;
                state_next       = (credit_reg != vend_price) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                coin_reject_next = coin_valid;
                if (chg_ready) begin
                    credit_next = credit_reg - chg_value;
                    if (credit_reg == chg_value) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, credit and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            credit_reg      <= '0;
            vend_item_reg   <= '0;
            coin_reject_reg <= 1'b0;
            sel_deny_reg    <= 1'b0;
            vend_valid_reg  <= 1'b0;
            chg_valid_reg   <= 1'b0;
            chg_coin_reg    <= COIN_5;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            credit_reg      <= credit_next;
            vend_item_reg   <= vend_item_next;
            coin_reject_reg <= coin_reject_next;
            sel_deny_reg    <= sel_deny_next;
            vend_valid_reg  <= (state_next == ST_VEND);
            chg_valid_reg   <= (state_next == ST_CHANGE);
            chg_coin_reg    <= (state_next == ST_CHANGE) ? greedy_coin : COIN_5;
            busy_reg        <= (state_next == ST_VEND) || (state_next == ST_CHANGE);
        end
    end

    assign coin_reject = coin_reject_reg;
    assign vend_valid  = vend_valid_reg;
    assign vend_item   = vend_item_reg;
    assign sel_deny    = sel_deny_reg;
    assign chg_valid   = chg_valid_reg;
    assign chg_coin    = chg_coin_reg;
    assign credit      = credit_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
// Build with VEND_STOCK_EN defined to exercise the stock counters as well.
`timescale 1ns/1ps
module tb_vend_ctrl_multi;

    localparam int NUM_ITEMS  = 4;
    localparam int CREDIT_W   = 8;
    localparam int MAX_CREDIT = 200;
    localparam int SEL_W      = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                coin_valid;
    logic [1:0]          coin_sel;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_item;
    logic                cancel;
    logic                chg_ready;
    logic                coin_reject;
    logic                vend_valid;
    logic [SEL_W-1:0]    vend_item;
    logic                sel_deny;
    logic                chg_valid;
    logic [1:0]          chg_coin;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
`ifdef VEND_STOCK_EN
    logic                stock_load;
    logic [SEL_W-1:0]    stock_item;
    logic [7:0]          stock_val;
`endif

    always #5 clk = ~clk;

    vend_ctrl_multi #(
        .NUM_ITEMS  (NUM_ITEMS),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .cancel      (cancel),
        .chg_ready   (chg_ready),
        .coin_reject (coin_reject),
        .vend_valid  (vend_valid),
        .vend_item   (vend_item),
        .sel_deny    (sel_deny),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .credit      (credit),
        .busy        (busy)
`ifdef VEND_STOCK_EN
        ,
        .stock_load  (stock_load),
        .stock_item  (stock_item),
        .stock_val   (stock_val)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: money held, whether a vend or a refund is in progress.
    int price_tab [NUM_ITEMS] = '{5, 7, 10, 15};
    int m_credit;
    bit m_vending;
    int m_vitem;
    bit m_refund;
    bit m_rej;
    bit m_deny;
`ifdef VEND_STOCK_EN
    int m_stock [NUM_ITEMS];
`endif

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    function automatic int coin_units(input int code);
        case (code)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 0;
        endcase
    endfunction

    // Code of the biggest coin that fits in amt.
    function automatic int best_coin(input int amt);
        if (amt >= 5) return 2;
        if (amt >= 2) return 1;
        return 0;
    endfunction

    function automatic bit has_stock(input int item);
`ifdef VEND_STOCK_EN
        return m_stock[item] > 0;
`else
        return (item >= 0);
`endif
    endfunction

    task automatic model_reset();
        m_credit  = 0;
        m_vending = 0;
        m_vitem   = 0;
        m_refund  = 0;
        m_rej     = 0;
        m_deny    = 0;
`ifdef VEND_STOCK_EN
        for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = 0;
`endif
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit cv, input int cs, input bit sv, input int si,
                              input bit cc, input bit rdy);
        int  val;
        bit  fits;
        val    = coin_units(cs);
        fits   = (cs != 3) && (m_credit + val <= MAX_CREDIT);
        m_rej  = 0;
        m_deny = 0;
        if (m_vending) begin
            m_credit -= price_tab[m_vitem];
`ifdef VEND_STOCK_EN
            if (m_stock[m_vitem] > 0) m_stock[m_vitem]--;
`endif
            m_vending = 0;
            m_refund  = (m_credit > 0);
            m_rej     = cv;
        end else if (m_refund) begin
            m_rej = cv;
            if (rdy) begin
                m_credit -= coin_units(best_coin(m_credit));
                if (m_credit == 0) m_refund = 0;
            end
        end else if (m_credit == 0) begin
            m_deny = sv;
            if (cv) begin
                if (fits) m_credit += val;
                else m_rej = 1;
            end
        end else begin
            if (cc) begin
                m_refund = 1;
                m_rej    = cv;
            end else if (sv) begin
                m_rej = cv;
                if (si < NUM_ITEMS && m_credit >= price_tab[si] && has_stock(si)) begin
                    m_vending = 1;
                    m_vitem   = si;
                end else begin
                    m_deny = 1;
                end
            end else if (cv) begin
                if (fits) m_credit += val;
                else m_rej = 1;
            end
        end
`ifdef VEND_STOCK_EN
        if (stock_load) m_stock[int'(stock_item)] = int'(stock_val);
`endif
    endtask

    task automatic compare_all();
        check("credit", int'(credit), m_credit);
        check("coin_reject", int'(coin_reject), int'(m_rej));
        check("sel_deny", int'(sel_deny), int'(m_deny));
        check("vend_valid", int'(vend_valid), int'(m_vending));
        if (m_vending) check("vend_item", int'(vend_item), m_vitem);
        check("chg_valid", int'(chg_valid), int'(m_refund));
        if (m_refund) check("chg_coin", int'(chg_coin), best_coin(m_credit));
        check("busy", int'(busy), int'(m_vending || m_refund));
    endtask

    // One clock of stimulus; outputs sampled 1ns after the edge.
    task automatic step(input bit cv, input int cs, input bit sv, input int si,
                        input bit cc, input bit rdy);
        coin_valid = cv;
        coin_sel   = 2'(cs);
        sel_valid  = sv;
        sel_item   = SEL_W'(si);
        cancel     = cc;
        chg_ready  = rdy;
        model_step(cv, cs, sv, si, cc, rdy);
        @(posedge clk);
        #1;
        compare_all();
        if (cv || sv || cc || vend_valid || (chg_valid && chg_ready))
            $display("t=%0t coin=%0d/%0d sel=%0d/%0d cancel=%0d -> credit=%0d rej=%0d deny=%0d vend=%0d/%0d chg=%0d/%0d",
                     $time, cv, cs, sv, si, cc, credit, coin_reject, sel_deny,
                     vend_valid, vend_item, chg_valid, chg_coin);
    endtask

    task automatic coin(input int cs);
        step(1'b1, cs, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Hand out change with the dispenser always ready; bounded.
    task automatic drain();
        int n;
        n = 0;
        while ((m_refund || m_vending) && n < 300) begin
            step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
            n++;
        end
        check("drain_done", int'(busy), 0);
    endtask

`ifdef VEND_STOCK_EN
    task automatic load_stock(input int item, input int val);
        stock_load = 1'b1;
        stock_item = SEL_W'(item);
        stock_val  = 8'(val);
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        stock_load = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        coin_valid = 1'b0;
        coin_sel   = 2'd0;
        sel_valid  = 1'b0;
        sel_item   = '0;
        cancel     = 1'b0;
        chg_ready  = 1'b0;
`ifdef VEND_STOCK_EN
        stock_load = 1'b0;
        stock_item = '0;
        stock_val  = 8'd0;
`endif
        model_reset();
        @(posedge clk);
        do_reset();
        check("rst_credit", int'(credit), 0);
        check("rst_vend_item", int'(vend_item), 0);
        check("rst_chg_coin", int'(chg_coin), 0);
        check("rst_chg_valid", int'(chg_valid), 0);

`ifdef VEND_STOCK_EN
        for (int i = 0; i < NUM_ITEMS; i++) load_stock(i, 5);
`endif

        // 25c + 10c, buy item 1 (price 7): exact, no change.
        coin(2);
        coin(1);
        check("t1_credit", int'(credit), 7);
        step(1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        check("t1_vend", int'(vend_valid), 1);
        check("t1_item", int'(vend_item), 1);
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        check("t1_credit0", int'(credit), 0);
        check("t1_nochg", int'(chg_valid), 0);

        // 25c + 25c, buy item 0 (price 5): 25c change with a 3-cycle stall.
        coin(2);
        coin(2);
        step(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
            check("t2_hold_valid", int'(chg_valid), 1);
            check("t2_hold_coin", int'(chg_coin), 2);
        end
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        check("t2_done_credit", int'(credit), 0);
        check("t2_done_valid", int'(chg_valid), 0);

        // Credit ceiling: 196 + 25c rejected, 200 reachable, then 5c rejected.
        for (int i = 0; i < 39; i++) coin(2);
        coin(0);
        check("t3_196", int'(credit), 196);
        coin(2);
        check("t3_reject", int'(coin_reject), 1);
        check("t3_keep", int'(credit), 196);
        coin(1);
        coin(1);
        check("t3_200", int'(credit), 200);
        coin(0);
        check("t3_full_reject", int'(coin_reject), 1);
        step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        drain();

        // 10c then item 3 (price 15): denied; cancel returns one 10c.
        coin(1);
        step(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
        check("t4_deny", int'(sel_deny), 1);
        check("t4_credit", int'(credit), 2);
        step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        check("t4_chg_coin", int'(chg_coin), 1);
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        check("t4_idle", int'(chg_valid), 0);

        // Credit 6 with cancel+select+coin together: refund 25c then 5c.
        coin(2);
        coin(0);
        step(1'b1, 0, 1'b1, 0, 1'b1, 1'b0);
        check("t5_reject", int'(coin_reject), 1);
        check("t5_novend", int'(vend_valid), 0);
        check("t5_coin25", int'(chg_coin), 2);
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        check("t5_coin5", int'(chg_coin), 0);
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        check("t5_idle", int'(busy), 0);

        // Selection with no credit is refused.
        step(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
        check("t6_idle_deny", int'(sel_deny), 1);

`ifdef VEND_STOCK_EN
        // One unit of item 2: second purchase denied.
        load_stock(2, 1);
        coin(2);
        coin(2);
        step(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        check("t7_vend1", int'(vend_valid), 1);
        drain();
        coin(2);
        coin(2);
        step(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        check("t7_sold_out", int'(sel_deny), 1);
        step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        drain();
`endif

        // Reset while change is pending discards the credit.
        coin(2);
        coin(2);
        step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        check("t8_chg", int'(chg_valid), 1);
        model_reset();
        do_reset();
        check("t8_drop", int'(chg_valid), 0);
        check("t8_credit", int'(credit), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit cv, sv, cc, rdy;
            int cs, si;
            cv  = ($urandom_range(0, 99) < 40);
            cs  = $urandom_range(0, 3);
            sv  = ($urandom_range(0, 99) < 12);
            si  = $urandom_range(0, NUM_ITEMS - 1);
            cc  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < 60);
`ifdef VEND_STOCK_EN
            stock_load = ($urandom_range(0, 99) < 6);
            stock_item = SEL_W'($urandom_range(0, NUM_ITEMS - 1));
            stock_val  = 8'($urandom_range(0, 3));
`endif
            step(cv, cs, sv, si, cc, rdy);
        end
`ifdef VEND_STOCK_EN
        stock_load = 1'b0;
`endif
        if (m_credit > 0 && !m_refund && !m_vending)
            step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
